frame_fetch_streamer: RTL and testbench

Reads a frame of 16-bit pixels from external memory in fixed 32-byte bursts and pushes it into a 17-bit-wide downstream FIFO, one pixel per write. Each frame and each row is framed by marker words. It sits between the memory arbiter (read_rq/read_ack/rd_data_valid) and the display-side pixel queue. It can crop a wider source frame, and optionally scale rows vertically.

---
 rtl/frame_fetch_streamer.sv | 203 ++++++++++++++++++++
 tb/tb_frame_fetch_streamer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_fetch_streamer.sv
// Fetches a frame in 32-byte bursts and streams marker-framed 16-bit pixels into a 17-bit FIFO.
// Latency: frame marker 2 cycles after start; each burst's pixels follow its 8th data beat.
// Backpressure: writes only when queue_full is low, at most every other cycle; FRAME_ROW_RESIZE_EN adds vertical scaling.
module frame_fetch_streamer #(
    parameter int MEMORY_BURST      = 32,
    parameter int FRAME_WIDTH       = 480,
    parameter int FRAME_HEIGHT      = 272,
    parameter int ORIG_FRAME_WIDTH  = 640,
    parameter int ORIG_FRAME_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [20:0] base_addr,
    input  logic        queue_full,
    input  logic        read_ack,
    input  logic [31:0] read_data,
    input  logic        rd_data_valid,
    output logic [16:0] queue_data_o,
    output logic        wr_en,
    output logic        read_rq,
    output logic [20:0] read_addr,
    output logic        mem_rd_en,
    output logic        download_done
);
    // Counter width covers columns, rows and the scaling remainder.
    localparam int CNT_W = $clog2(FRAME_WIDTH + 3 * FRAME_HEIGHT + ORIG_FRAME_HEIGHT + 2);
    localparam logic [CNT_W-1:0] FW = CNT_W'(FRAME_WIDTH);
    localparam logic [CNT_W-1:0] FH = CNT_W'(FRAME_HEIGHT);
    localparam logic [20:0] PITCH = 21'(ORIG_FRAME_WIDTH);
    localparam logic [2:0] BEAT_LAST = 3'(MEMORY_BURST / 4 - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FRAME_MARK, S_ROW_MARK, S_BURST, S_BEATS,
        S_UPLOAD, S_ROW_END, S_SKIP, S_FRAME_END
    } state_t;

    state_t state, state_n;
    logic [20:0] addr, addr_n, row_start, row_start_n;
    logic [CNT_W-1:0] row_cnt, row_cnt_n, col_cnt, col_cnt_n;
    logic [2:0] beat_cnt, beat_cnt_n;
    logic [3:0] pix_idx, pix_idx_n;
    logic [16:0] q_n;
    logic wr_n, rd_en_n, done_n;
    logic can_wr, col_last, row_last;
    logic [4:0] emitted;
    logic [15:0] cache [16];

    assign can_wr    = !queue_full && !wr_en;
    assign col_last  = (col_cnt + CNT_W'(1)) == FW;
    assign row_last  = (row_cnt + CNT_W'(1)) == FH;
    assign emitted   = {1'b0, pix_idx} + 5'd1;
    assign read_rq   = (state == S_BURST) || (state == S_BEATS);
    assign read_addr = addr;

`ifdef FRAME_ROW_RESIZE_EN
    localparam logic [CNT_W-1:0] OFH = CNT_W'(ORIG_FRAME_HEIGHT);
    localparam logic [CNT_W-1:0] FH2 = CNT_W'(2 * FRAME_HEIGHT);
    localparam logic [CNT_W-1:0] FH3 = CNT_W'(3 * FRAME_HEIGHT);
    logic [CNT_W-1:0] rem, rem_n, rem_sum, rem_adv;
    logic [1:0] inc, skip, skip_n;

    // rem tracks (r*OFH) mod FH, so inc is the source-row step for the next output row.
    assign rem_sum = rem + OFH;
    always_comb begin
        inc     = 2'd0;
        rem_adv = rem_sum;
        if (rem_sum >= FH3) begin
            inc = 2'd3; rem_adv = rem_sum - FH3;
        end else if (rem_sum >= FH2) begin
            inc = 2'd2; rem_adv = rem_sum - FH2;
        end else if (rem_sum >= FH) begin
            inc = 2'd1; rem_adv = rem_sum - FH;
        end
    end
`endif

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        row_start_n = row_start;
        row_cnt_n   = row_cnt;
        col_cnt_n   = col_cnt;
        beat_cnt_n  = beat_cnt;
        pix_idx_n   = pix_idx;
        q_n         = queue_data_o;
        wr_n        = 1'b0;
        rd_en_n     = 1'b0;
        done_n      = 1'b0;
`ifdef FRAME_ROW_RESIZE_EN
        rem_n       = rem;
        skip_n      = skip;
`endif
        case (state)
            S_IDLE: begin
                addr_n = base_addr;
                if (start) begin
                    row_cnt_n = '0;
`ifdef FRAME_ROW_RESIZE_EN
                    rem_n = '0;
`endif
                    state_n = S_FRAME_MARK;
                end
            end
            S_FRAME_MARK: if (can_wr) begin
                wr_n = 1'b1; q_n = 17'h10000; state_n = S_ROW_MARK;
            end
            S_ROW_MARK: if (can_wr) begin
                wr_n = 1'b1; q_n = 17'h10001;
                col_cnt_n = '0; row_start_n = addr; state_n = S_BURST;
            end
            S_BURST: if (read_ack) begin
                rd_en_n = 1'b1; beat_cnt_n = '0; state_n = S_BEATS;
            end
            S_BEATS: if (rd_data_valid) begin
                beat_cnt_n = beat_cnt + 3'd1;
                if (beat_cnt == BEAT_LAST) begin
                    pix_idx_n = '0; state_n = S_UPLOAD;
                end
            end
            S_UPLOAD: if (can_wr) begin
                wr_n = 1'b1;
                q_n = {1'b0, cache[pix_idx]};
                col_cnt_n = col_cnt + CNT_W'(1);
                pix_idx_n = pix_idx + 4'd1;
                if (pix_idx == 4'd15 || col_last) begin
                    addr_n  = addr + {16'd0, emitted};
                    state_n = col_last ? S_ROW_END : S_BURST;
                end
            end
            S_ROW_END: begin
                row_cnt_n = row_cnt + CNT_W'(1);
`ifdef FRAME_ROW_RESIZE_EN
                rem_n  = rem_adv;
                addr_n = (inc == 2'd0) ? row_start : row_start + PITCH;
                if (inc > 2'd1) begin
                    skip_n = inc - 2'd1; state_n = S_SKIP;
                end else begin
                    state_n = row_last ? S_FRAME_END : S_ROW_MARK;
                end
`else
                addr_n  = row_start + PITCH;
                state_n = row_last ? S_FRAME_END : S_ROW_MARK;
`endif
            end
`ifdef FRAME_ROW_RESIZE_EN
            S_SKIP: begin
                addr_n = addr + PITCH;
                skip_n = skip - 2'd1;
                if (skip == 2'd1) state_n = (row_cnt == FH) ? S_FRAME_END : S_ROW_MARK;
            end
`endif
            S_FRAME_END: if (can_wr) begin
                wr_n = 1'b1; q_n = 17'h1FFFF; done_n = 1'b1; state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            addr          <= '0;
            row_start     <= '0;
            row_cnt       <= '0;
            col_cnt       <= '0;
            beat_cnt      <= '0;
            pix_idx       <= '0;
            queue_data_o  <= '0;
            wr_en         <= 1'b0;
            mem_rd_en     <= 1'b0;
            download_done <= 1'b0;
`ifdef FRAME_ROW_RESIZE_EN
            rem           <= '0;
            skip          <= '0;
`endif
        end else begin
            state         <= state_n;
            addr          <= addr_n;
            row_start     <= row_start_n;
            row_cnt       <= row_cnt_n;
            col_cnt       <= col_cnt_n;
            beat_cnt      <= beat_cnt_n;
            pix_idx       <= pix_idx_n;
            queue_data_o  <= q_n;
            wr_en         <= wr_n;
            mem_rd_en     <= rd_en_n;
            download_done <= done_n;
`ifdef FRAME_ROW_RESIZE_EN
            rem           <= rem_n;
            skip          <= skip_n;
`endif
        end
    end

    // Beat k fills pixels 2k (low half) and 2k+1 (high half).
    always_ff @(posedge clk) begin
        if (state == S_BEATS && rd_data_valid) begin
            cache[{beat_cnt, 1'b0}] <= read_data[15:0];
            cache[{beat_cnt, 1'b1}] <= read_data[31:16];
        end
    end
endmodule

// File: tb/tb_frame_fetch_streamer.sv
// Bench for frame_fetch_streamer: random memory timing and FIFO backpressure against a frame-level model.
// Latency: expected stream is derived from source-row/column arithmetic, not cycle timing.
// Backpressure: random queue_full plus one 10-cycle stall mid-row.
`timescale 1ns/1ps
module tb_frame_fetch_streamer;
    localparam int FW  = 20;
    localparam int FH  = 3;
    localparam int OFW = 40;
    localparam int OFH = 7;

    logic clk = 1'b0;
    logic reset_n, start, queue_full, read_ack, rd_data_valid;
    logic wr_en, read_rq, mem_rd_en, download_done;
    logic [20:0] base_addr, read_addr;
    logic [31:0] read_data;
    logic [16:0] queue_data_o;

    int n_vec = 0, n_err = 0;
    logic [16:0] exp_q[$];
    logic [20:0] exp_burst[$];
    int done_cnt = 0, pix_seen = 0;
    logic prev_wr = 1'b0, prev_qf = 1'b0;
    int m_phase = 0, m_delay = 0, m_beat = 0, m_gap = 0, rd_chk = 0;
    logic [20:0] m_addr, m_a;
    int hold_cnt = 0;
    bit held = 0;

    frame_fetch_streamer #(
        .MEMORY_BURST(32), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
        .ORIG_FRAME_WIDTH(OFW), .ORIG_FRAME_HEIGHT(OFH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .queue_full(queue_full), .read_ack(read_ack), .read_data(read_data),
        .rd_data_valid(rd_data_valid), .queue_data_o(queue_data_o), .wr_en(wr_en),
        .read_rq(read_rq), .read_addr(read_addr), .mem_rd_en(mem_rd_en),
        .download_done(download_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pix(input logic [20:0] a);
        return a[15:0] ^ {a[20:16], 11'h2A5};
    endfunction

    // Source row feeding output row r.
    function automatic int src_row(input int r);
`ifdef FRAME_ROW_RESIZE_EN
        return (r * OFH) / FH;
`else
        return r;
`endif
    endfunction

    // FIFO-side monitor.
    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_en) begin
                check_eq("wr_gap", {31'b0, prev_wr}, 0);
                check_eq("wr_when_full", {31'b0, prev_qf}, 0);
                if (exp_q.size() == 0) check_eq("wr_no_expect", {31'b0, wr_en}, 0);
                else check_eq("stream", {15'b0, queue_data_o}, {15'b0, exp_q.pop_front()});
                if (!queue_data_o[16]) pix_seen++;
            end
            if (download_done) begin
                done_cnt++;
                check_eq("done_with_end", {14'b0, wr_en, queue_data_o}, {14'b0, 1'b1, 17'h1FFFF});
            end
            prev_wr = wr_en;
            prev_qf = queue_full;
        end else begin
            prev_wr = 1'b0;
            prev_qf = 1'b0;
        end
    end

    // Memory responder: random grant delay, gapped beats, occasional stray 9th beat.
    initial begin
        read_ack = 1'b0; rd_data_valid = 1'b0; read_data = '0;
        forever begin
            @(posedge clk); #1;
            read_ack = 1'b0; rd_data_valid = 1'b0;
            if (!reset_n) begin
                m_phase = 0; rd_chk = 0;
                continue;
            end
            if (rd_chk == 1) begin
                check_eq("rd_en_pulse", {31'b0, mem_rd_en}, 1); rd_chk = 2;
            end else if (rd_chk == 2) begin
                check_eq("rd_en_single", {31'b0, mem_rd_en}, 0); rd_chk = 0;
            end
            case (m_phase)
                0: if (read_rq) begin
                    if (exp_burst.size() == 0) check_eq("burst_unexpected", {31'b0, read_rq}, 0);
                    else check_eq("burst_addr", {11'b0, read_addr}, {11'b0, exp_burst.pop_front()});
                    m_addr = read_addr; m_delay = $urandom_range(0, 5); m_phase = 1;
                end
                1: begin
                    check_eq("rq_wait", {31'b0, read_rq}, 1);
                    check_eq("rq_addr", {11'b0, read_addr}, {11'b0, m_addr});
                    if (m_delay == 0) begin
                        read_ack = 1'b1; rd_chk = 1; m_beat = 0;
                        m_gap = $urandom_range(0, 2); m_phase = 2;
                    end else m_delay--;
                end
                2: begin
                    check_eq("rq_beats", {31'b0, read_rq}, 1);
                    if (m_gap > 0) m_gap--;
                    else begin
                        m_a = m_addr + 21'(2 * m_beat);
                        rd_data_valid = 1'b1;
                        read_data = {pix(m_a + 21'd1), pix(m_a)};
                        m_beat++;
                        m_gap = $urandom_range(0, 2);
                        if (m_beat == 8) m_phase = 3;
                    end
                end
                default: begin
                    check_eq("rq_drop", {31'b0, read_rq}, 0);
                    if ($urandom_range(0, 1) == 1) begin
                        rd_data_valid = 1'b1; read_data = $urandom;
                    end
                    m_phase = 0;
                end
            endcase
        end
    end

    // Downstream FIFO fullness.
    initial begin
        queue_full = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hold_cnt > 0) begin
                queue_full = 1'b1; hold_cnt--;
            end else if (!held && pix_seen >= 7) begin
                held = 1; hold_cnt = 9; queue_full = 1'b1;
            end else queue_full = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic start_frame(input logic [20:0] base);
        logic [20:0] rs;
        exp_q.push_back(17'h10000);
        for (int r = 0; r < FH; r++) begin
            rs = base + 21'(src_row(r) * OFW);
            exp_q.push_back(17'h10001);
            for (int c = 0; c < FW; c++) exp_q.push_back({1'b0, pix(rs + 21'(c))});
            for (int c = 0; c < FW; c += 16) exp_burst.push_back(rs + 21'(c));
        end
        exp_q.push_back(17'h1FFFF);
        @(posedge clk); #1;
        base_addr = base; start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_frame();
        int d0 = done_cnt;
        int t = 0;
        while (done_cnt == d0 && t < 20000) begin
            @(negedge clk); t++;
        end
        repeat (5) @(negedge clk);
        check_eq("done_pulses", done_cnt - d0, 1);
        check_eq("stream_left", exp_q.size(), 0);
        check_eq("bursts_left", exp_burst.size(), 0);
    endtask

    task automatic run_frame(input logic [20:0] base);
        start_frame(base);
        repeat (30) @(posedge clk);
        #1 start = 1'b1; base_addr = 21'($urandom);
        @(posedge clk);
        #1 start = 1'b0;
        wait_frame();
    endtask

    initial begin
        int t;
        reset_n = 1'b0; start = 1'b0; base_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_wr_en", {31'b0, wr_en}, 0);
        check_eq("rst_read_rq", {31'b0, read_rq}, 0);
        check_eq("rst_mem_rd_en", {31'b0, mem_rd_en}, 0);
        check_eq("rst_done", {31'b0, download_done}, 0);
        check_eq("rst_qdata", {15'b0, queue_data_o}, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        run_frame(21'h000100);
        run_frame(21'h1FFFF0);
        run_frame(21'($urandom));

        start_frame(21'h00ABCD);
        t = 0;
        while (m_phase != 2 && t < 2000) begin
            @(negedge clk); t++;
        end
        check_eq("reach_beats", m_phase, 2);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_wr_en", {31'b0, wr_en}, 0);
        check_eq("arst_read_rq", {31'b0, read_rq}, 0);
        check_eq("arst_mem_rd_en", {31'b0, mem_rd_en}, 0);
        check_eq("arst_done", {31'b0, download_done}, 0);
        check_eq("arst_qdata", {15'b0, queue_data_o}, 0);
        exp_q.delete();
        exp_burst.delete();
        @(posedge clk); #3 reset_n = 1'b1;
        run_frame(21'h000F00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
